// File: rtl/seven_segment_decoder.sv
// seven_segment_decoder
//   Receive-side checker for the active-low seven-segment bus driven by the
//   digit controller. It debounces the bus and decodes stable patterns back
//   to a BCD digit or blank. It also flags unrecognised patterns and digits
//   that break the controller's count order.
//
// Parameters
//   STABLE_CYCLES  identical consecutive samples needed to accept (1..255)
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   leds_in      segment bus, active-low, bit 6 = a ... bit 0 = g
//   clear        synchronous clear of error flags, error count and history
//   digit        last accepted digit (0..9)
//   blank        last accepted pattern was all segments off
//   digit_valid  one-cycle pulse when a valid pattern is accepted
//   pattern_err  sticky: an unrecognised pattern was accepted
//   seq_err      sticky: an accepted pattern broke the count order
//   err_count    saturating count of pattern and sequence errors
module seven_segment_decoder #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [6:0] leds_in,
  input  logic       clear,
  output logic [3:0] digit,
  output logic       blank,
  output logic       digit_valid,
  output logic       pattern_err,
  output logic       seq_err,
  output logic [7:0] err_count
);

  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);
  localparam logic [6:0] PAT_BLANK  = 7'b1111111;

  // What the previously accepted pattern was, used to decide whether the
  // count-order check applies to the next accept.
  typedef enum logic [1:0] {
    HIST_NONE,
    HIST_VALID,
    HIST_UNKNOWN
  } hist_t;

  logic [6:0] samp, samp_next;
  logic [7:0] cnt, cnt_next;
  logic [6:0] last_acc, last_acc_next;
  logic       have_last, have_last_next;
  hist_t      hist, hist_next;

  logic [3:0] digit_next;
  logic       blank_next;
  logic       digit_valid_next;
  logic       pattern_err_next;
  logic       seq_err_next;
  logic [7:0] err_count_next;

  logic       accept;
  logic       dec_valid;
  logic       dec_blank;
  logic [3:0] dec_digit;
  logic       seq_ok;
  logic       raise_err;

  // Decode the sampled pattern. Only the ten digit shapes and the all-off
  // pattern are recognised; anything else is reported as invalid.
  always_comb begin
    dec_valid = 1'b1;
    dec_blank = 1'b0;
    dec_digit = 4'd0;
    case (samp)
      7'b0000001: dec_digit = 4'd0;
      7'b1001111: dec_digit = 4'd1;
      7'b0010010: dec_digit = 4'd2;
      7'b0000110: dec_digit = 4'd3;
      7'b1001100: dec_digit = 4'd4;
      7'b0100100: dec_digit = 4'd5;
      7'b0100000: dec_digit = 4'd6;
      7'b0001111: dec_digit = 4'd7;
      7'b0000000: dec_digit = 4'd8;
      7'b0000100: dec_digit = 4'd9;
      PAT_BLANK:  dec_blank = 1'b1;
      default:    dec_valid = 1'b0;
    endcase
  end

  // Count-order check against the last valid accept. The controller counts
  // 0..9, then blank, then back to 0. Digit 0 is always legal because the
  // controller may have been reset.
  always_comb begin
    seq_ok = 1'b0;
    if (dec_blank) begin
      seq_ok = !blank && (digit == 4'd9);
    end else if (dec_digit == 4'd0) begin
      seq_ok = 1'b1;
    end else begin
      seq_ok = !blank && (dec_digit == digit + 4'd1);
    end
  end

  // Next-state logic. The stability counter reaching its limit while the
  // held pattern differs from the last accept is the acceptance event. The
  // accepted pattern is recorded, so a long hold never re-accepts. Clear
  // wins over any error raised in the same cycle, but the accept itself
  // still updates the digit outputs.
  always_comb begin
    samp_next        = leds_in;
    cnt_next         = cnt;
    last_acc_next    = last_acc;
    have_last_next   = have_last;
    hist_next        = hist;
    digit_next       = digit;
    blank_next       = blank;
    digit_valid_next = 1'b0;
    pattern_err_next = pattern_err;
    seq_err_next     = seq_err;
    err_count_next   = err_count;
    raise_err        = 1'b0;

    if (leds_in != samp) begin
      cnt_next = 8'd1;
    end else if (cnt < STABLE_MAX) begin
      cnt_next = cnt + 8'd1;
    end

    accept = (cnt == STABLE_MAX) && (!have_last || (samp != last_acc));

    if (accept) begin
      last_acc_next  = samp;
      have_last_next = 1'b1;
      if (dec_valid) begin
        digit_valid_next = 1'b1;
        blank_next       = dec_blank;
        if (!dec_blank) begin
          digit_next = dec_digit;
        end
        if ((hist == HIST_VALID) && !seq_ok) begin
          seq_err_next = 1'b1;
          raise_err    = 1'b1;
        end
        hist_next = HIST_VALID;
      end else begin
        pattern_err_next = 1'b1;
        raise_err        = 1'b1;
        hist_next        = HIST_UNKNOWN;
      end
    end

    if (raise_err && (err_count != 8'hFF)) begin
      err_count_next = err_count + 8'd1;
    end

    if (clear) begin
      pattern_err_next = 1'b0;
      seq_err_next     = 1'b0;
      err_count_next   = 8'd0;
      hist_next        = HIST_NONE;
    end
  end

  // State and output registers. Reset preloads the sample with the all-off
  // pattern and forgets the last accept, so counting restarts from the first
  // post-reset sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      samp        <= PAT_BLANK;
      cnt         <= 8'd0;
      last_acc    <= PAT_BLANK;
      have_last   <= 1'b0;
      hist        <= HIST_NONE;
      digit       <= 4'd0;
      blank       <= 1'b0;
      digit_valid <= 1'b0;
      pattern_err <= 1'b0;
      seq_err     <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      samp        <= samp_next;
      cnt         <= cnt_next;
      last_acc    <= last_acc_next;
      have_last   <= have_last_next;
      hist        <= hist_next;
      digit       <= digit_next;
      blank       <= blank_next;
      digit_valid <= digit_valid_next;
      pattern_err <= pattern_err_next;
      seq_err     <= seq_err_next;
      err_count   <= err_count_next;
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// tb_seven_segment_decoder
//   Directed bench for seven_segment_decoder with the default stability
//   length of 4. Expected values are hand-computed from the decode table and
//   the count order of the digit controller.
module tb_seven_segment_decoder;

  localparam logic [6:0] PAT_0     = 7'b0000001;
  localparam logic [6:0] PAT_2     = 7'b0010010;
  localparam logic [6:0] PAT_3     = 7'b0000110;
  localparam logic [6:0] PAT_4     = 7'b1001100;
  localparam logic [6:0] PAT_5     = 7'b0100100;
  localparam logic [6:0] PAT_7     = 7'b0001111;
  localparam logic [6:0] PAT_9     = 7'b0000100;
  localparam logic [6:0] PAT_BLANK = 7'b1111111;
  localparam logic [6:0] PAT_BAD   = 7'b1110000;

  logic       clk;
  logic       reset_n;
  logic [6:0] leds_in;
  logic       clear;
  logic [3:0] digit;
  logic       blank;
  logic       digit_valid;
  logic       pattern_err;
  logic       seq_err;
  logic [7:0] err_count;

  int numChecks;
  int numErrors;
  int pulseCount;

  seven_segment_decoder #(.STABLE_CYCLES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .leds_in     (leds_in),
    .clear       (clear),
    .digit       (digit),
    .blank       (blank),
    .digit_valid (digit_valid),
    .pattern_err (pattern_err),
    .seq_err     (seq_err),
    .err_count   (err_count)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive a pattern for a number of clock edges, sampling 1 ns after each
  // edge and counting digit_valid pulses seen along the way.
  task automatic applyStimulus(input logic [6:0] pattern, input int cycles);
    leds_in = pattern;
    repeat (cycles) begin
      @(posedge clk);
      #1;
      if (digit_valid) begin
        pulseCount++;
      end
    end
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string name, input logic [8:0] observed,
                             input logic [8:0] expected);
    numChecks++;
    assert (observed === expected) else begin
      numErrors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", name, observed, expected);
    end
  endtask

  // Pulse clear for one edge while the bus is quiet.
  task automatic pulseClear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  // Directed sequence covering debounce, count order, invalid patterns,
  // saturation, clear priority and mid-count reset.
  initial begin
    logic [6:0] seqPat [11];
    logic [3:0] seqDigit [11];
    logic       seqBlank [11];

    seqPat   = '{7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
                 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b1111111,
                 7'b0000001};
    seqDigit = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9, 4'd0};
    seqBlank = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    numChecks  = 0;
    numErrors  = 0;
    pulseCount = 0;
    reset_n    = 1'b0;
    clear      = 1'b0;
    leds_in    = PAT_BLANK;

    #12;
    checkOutput("reset digit", 9'(digit), 9'd0);
    checkOutput("reset blank", 9'(blank), 9'd0);
    checkOutput("reset digit_valid", 9'(digit_valid), 9'd0);
    checkOutput("reset err_count", 9'(err_count), 9'd0);

    @(negedge clk);
    reset_n = 1'b1;
    $display("[TB] first accept after five edges");
    applyStimulus(PAT_0, 4);
    checkOutput("no early pulse", 9'(pulseCount), 9'd0);
    applyStimulus(PAT_0, 1);
    checkOutput("first digit_valid", 9'(digit_valid), 9'd1);
    checkOutput("first digit", 9'(digit), 9'd0);
    applyStimulus(PAT_0, 20);
    checkOutput("hold no re-accept", 9'(pulseCount), 9'd1);
    checkOutput("first errors", 9'({pattern_err, seq_err, err_count[6:0]}), 9'd0);

    $display("[TB] full count order");
    pulseCount = 0;
    for (int i = 0; i < 11; i++) begin
      applyStimulus(seqPat[i], 6);
      checkOutput($sformatf("order digit %0d", i), 9'(digit), 9'(seqDigit[i]));
      checkOutput($sformatf("order blank %0d", i), 9'(blank), 9'(seqBlank[i]));
    end
    checkOutput("order pulses", 9'(pulseCount), 9'd11);
    checkOutput("order seq_err", 9'(seq_err), 9'd0);
    checkOutput("order err_count", 9'(err_count), 9'd0);

    $display("[TB] glitch rejection and sequence error");
    pulseClear();
    pulseCount = 0;
    applyStimulus(PAT_3, 6);
    applyStimulus(PAT_4, 2);
    applyStimulus(PAT_5, 6);
    checkOutput("glitch pulses", 9'(pulseCount), 9'd2);
    checkOutput("glitch digit", 9'(digit), 9'd5);
    checkOutput("glitch seq_err", 9'(seq_err), 9'd1);
    checkOutput("glitch err_count", 9'(err_count), 9'd1);

    $display("[TB] invalid pattern");
    pulseClear();
    checkOutput("clear seq_err", 9'(seq_err), 9'd0);
    applyStimulus(PAT_2, 6);
    pulseCount = 0;
    applyStimulus(PAT_BAD, 6);
    checkOutput("bad no pulse", 9'(pulseCount), 9'd0);
    checkOutput("bad pattern_err", 9'(pattern_err), 9'd1);
    checkOutput("bad digit kept", 9'(digit), 9'd2);
    checkOutput("bad err_count", 9'(err_count), 9'd1);
    applyStimulus(PAT_7, 6);
    checkOutput("after bad pulse", 9'(pulseCount), 9'd1);
    checkOutput("after bad digit", 9'(digit), 9'd7);
    checkOutput("after bad seq_err", 9'(seq_err), 9'd0);
    checkOutput("after bad err_count", 9'(err_count), 9'd1);

    $display("[TB] saturation and clear on accept");
    pulseClear();
    pulseCount = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus((i % 2 == 1) ? PAT_5 : PAT_2, 5);
    end
    checkOutput("sat pulses", 9'(pulseCount), 9'd300);
    checkOutput("sat err_count", 9'(err_count), 9'd255);
    checkOutput("sat seq_err", 9'(seq_err), 9'd1);
    applyStimulus(PAT_2, 4);
    clear = 1'b1;
    applyStimulus(PAT_2, 1);
    clear = 1'b0;
    checkOutput("clear accept valid", 9'(digit_valid), 9'd1);
    checkOutput("clear accept digit", 9'(digit), 9'd2);
    checkOutput("clear accept err_count", 9'(err_count), 9'd0);
    checkOutput("clear accept flags", 9'({pattern_err, seq_err}), 9'd0);

    $display("[TB] reset mid-count");
    applyStimulus(PAT_9, 2);
    reset_n = 1'b0;
    #1;
    checkOutput("async reset digit", 9'(digit), 9'd0);
    checkOutput("async reset valid", 9'(digit_valid), 9'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pulseCount = 0;
    applyStimulus(PAT_9, 4);
    checkOutput("post reset no early pulse", 9'(pulseCount), 9'd0);
    applyStimulus(PAT_9, 1);
    checkOutput("post reset valid", 9'(digit_valid), 9'd1);
    checkOutput("post reset digit", 9'(digit), 9'd9);
    checkOutput("post reset seq_err", 9'(seq_err), 9'd0);

    $display("Result: errors=%0d of %0d checks", numErrors, numChecks);
    $finish;
  end

endmodule
